link_motion_ctrl: RTL and testbench

Per-frame movement controller for the player sprite. Once per video frame it turns the current keyboard keycode into a new sprite position, facing direction and walk-animation phase. It consumes the `collision` flag raised by the sprite/background renderer and drives that renderer's `spriteX`/`spriteY`/`sprite_size` inputs. It sits directly upstream of the sprite renderer and runs on the pixel clock.

---
 rtl/link_motion_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_link_motion_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/link_motion_ctrl.sv
// rtl/link_motion_ctrl.sv - per-frame player sprite movement controller
module link_motion_ctrl #(
    parameter int STEP         = 2,
    parameter int SIZE         = 32,
    parameter int X_START      = 304,
    parameter int Y_START      = 224,
    parameter int X_MIN        = 0,
    parameter int X_MAX        = 608,
    parameter int Y_MIN        = 0,
    parameter int Y_MAX        = 448,
    parameter int BLOCK_FRAMES = 8,
    parameter int ANIM_DIV     = 8
) (
    input  logic       vga_clk,
    input  logic       Reset,
    input  logic       vs,
    input  logic [7:0] keycode,
    input  logic       collision,
    output logic [9:0] spriteX,
    output logic [9:0] spriteY,
    output logic [9:0] sprite_size,
    output logic [1:0] dir,
    output logic       anim_frame,
    output logic       moving,
    output logic       frame_tick
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_MOVE    = 2'd1;
    localparam logic [1:0] S_BLOCKED = 2'd2;

    localparam logic [1:0] D_DOWN  = 2'b00;
    localparam logic [1:0] D_UP    = 2'b01;
    localparam logic [1:0] D_LEFT  = 2'b10;
    localparam logic [1:0] D_RIGHT = 2'b11;

    localparam int BW = (BLOCK_FRAMES > 0) ? $clog2(BLOCK_FRAMES + 1) : 1;
    localparam int AW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    localparam logic [10:0] STEP_W  = 11'(STEP);
    localparam logic [10:0] X_MIN_W = 11'(X_MIN);
    localparam logic [10:0] X_MAX_W = 11'(X_MAX);
    localparam logic [10:0] Y_MIN_W = 11'(Y_MIN);
    localparam logic [10:0] Y_MAX_W = 11'(Y_MAX);

    logic [1:0]    state;
    logic          vs_d;
    logic [9:0]    prev_x;
    logic [9:0]    prev_y;
    logic [1:0]    blk_dir;
    logic [BW-1:0] blk_cnt;
    logic [AW-1:0] anim_cnt;

    logic          tick;
    logic          key_valid;
    logic [1:0]    key_dir;
    logic [10:0]   x_ext;
    logic [10:0]   y_ext;
    logic [10:0]   step_x;
    logic [10:0]   step_y;
    logic          do_step;
    logic [BW-1:0] cnt_dec;

    logic [1:0]    nxt_state;
    logic [9:0]    nxt_x;
    logic [9:0]    nxt_y;
    logic [1:0]    nxt_dir;
    logic [9:0]    nxt_prev_x;
    logic [9:0]    nxt_prev_y;
    logic [1:0]    nxt_blk_dir;
    logic [BW-1:0] nxt_blk_cnt;
    logic [AW-1:0] nxt_anim_cnt;
    logic          nxt_anim_frame;

    assign sprite_size = 10'(SIZE);

    // Frame boundary is the rising edge of vs, i.e. the end of the sync pulse
    assign tick = vs & ~vs_d;

    // Keycode decode into a direction and a valid flag
    always_comb begin
        key_valid = 1'b1;
        key_dir   = D_DOWN;
        case (keycode)
            8'h07:   key_dir = D_RIGHT;
            8'h1A:   key_dir = D_UP;
            8'h04:   key_dir = D_LEFT;
            8'h16:   key_dir = D_DOWN;
            default: key_valid = 1'b0;
        endcase
    end

    // Candidate position one step in the key direction, clamped to the legal window
    always_comb begin
        x_ext  = {1'b0, spriteX};
        y_ext  = {1'b0, spriteY};
        step_x = x_ext;
        step_y = y_ext;
        case (key_dir)
            D_RIGHT: step_x = (x_ext + STEP_W > X_MAX_W) ? X_MAX_W : x_ext + STEP_W;
            D_LEFT:  step_x = (x_ext < X_MIN_W + STEP_W) ? X_MIN_W : x_ext - STEP_W;
            D_DOWN:  step_y = (y_ext + STEP_W > Y_MAX_W) ? Y_MAX_W : y_ext + STEP_W;
            default: step_y = (y_ext < Y_MIN_W + STEP_W) ? Y_MIN_W : y_ext - STEP_W;
        endcase
    end

    // Next-frame FSM decision; only applied on a tick
    always_comb begin
        nxt_state   = state;
        nxt_x       = spriteX;
        nxt_y       = spriteY;
        nxt_dir     = dir;
        nxt_prev_x  = prev_x;
        nxt_prev_y  = prev_y;
        nxt_blk_dir = blk_dir;
        nxt_blk_cnt = blk_cnt;
        do_step     = 1'b0;
        cnt_dec     = (blk_cnt == '0) ? '0 : blk_cnt - 1'b1;
        case (state)
            S_IDLE: begin
                if (key_valid && !((blk_cnt != '0) && (key_dir == blk_dir))) begin
                    do_step   = 1'b1;
                    nxt_state = S_MOVE;
                end
            end
            S_MOVE: begin
                // The frame just drawn overlapped the background: undo the last step
                if (collision) begin
                    nxt_x       = prev_x;
                    nxt_y       = prev_y;
                    nxt_blk_dir = dir;
                    nxt_blk_cnt = BW'(BLOCK_FRAMES);
                    nxt_state   = S_BLOCKED;
                end else if (key_valid) begin
                    do_step = 1'b1;
                end else begin
                    nxt_state = S_IDLE;
                end
            end
            S_BLOCKED: begin
                if (key_valid && (key_dir != blk_dir)) begin
                    do_step     = 1'b1;
                    nxt_blk_cnt = '0;
                    nxt_state   = S_MOVE;
                end else begin
                    nxt_blk_cnt = cnt_dec;
                    if (cnt_dec == '0) begin
                        nxt_state = S_IDLE;
                    end
                end
            end
            default: nxt_state = S_IDLE;
        endcase
        if (do_step) begin
            nxt_prev_x = spriteX;
            nxt_prev_y = spriteY;
            nxt_x      = 10'(step_x);
            nxt_y      = 10'(step_y);
            nxt_dir    = key_dir;
        end
    end

    // Walk animation advances once per frame spent moving
    always_comb begin
        nxt_anim_cnt   = '0;
        nxt_anim_frame = anim_frame;
        if (nxt_state == S_MOVE) begin
            if (anim_cnt == AW'(ANIM_DIV - 1)) begin
                nxt_anim_frame = ~anim_frame;
            end else begin
                nxt_anim_cnt = anim_cnt + 1'b1;
            end
        end
    end

    // Registered state; everything but the edge detector only moves on a tick
    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            state      <= S_IDLE;
            vs_d       <= 1'b0;
            frame_tick <= 1'b0;
            spriteX    <= 10'(X_START);
            spriteY    <= 10'(Y_START);
            prev_x     <= 10'(X_START);
            prev_y     <= 10'(Y_START);
            dir        <= D_DOWN;
            blk_dir    <= D_DOWN;
            blk_cnt    <= '0;
            anim_cnt   <= '0;
            anim_frame <= 1'b0;
            moving     <= 1'b0;
        end else begin
            vs_d       <= vs;
            frame_tick <= tick;
            if (tick) begin
                state      <= nxt_state;
                spriteX    <= nxt_x;
                spriteY    <= nxt_y;
                prev_x     <= nxt_prev_x;
                prev_y     <= nxt_prev_y;
                dir        <= nxt_dir;
                blk_dir    <= nxt_blk_dir;
                blk_cnt    <= nxt_blk_cnt;
                anim_cnt   <= nxt_anim_cnt;
                anim_frame <= nxt_anim_frame;
                moving     <= (nxt_state == S_MOVE);
            end
        end
    end

endmodule

// File: tb/tb_link_motion_ctrl.sv
// tb/tb_link_motion_ctrl.sv - scoreboard bench for link_motion_ctrl
module tb_link_motion_ctrl;

    logic       clk = 1'b0;
    logic       rst_m;
    logic       rst_l;
    logic       vs;
    logic [7:0] keycode;
    logic       collision;

    logic [9:0] x_m, y_m, sz_m, x_l, y_l, sz_l;
    logic [1:0] d_m, d_l;
    logic       a_m, a_l, mv_m, mv_l, ft_m, ft_l;

    typedef struct {
        int x;
        int y;
        int d;
        int m;
        int a;
    } exp_t;

    exp_t q_m[$];
    exp_t q_l[$];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    link_motion_ctrl dut_m (
        .vga_clk(clk), .Reset(rst_m), .vs(vs), .keycode(keycode), .collision(collision),
        .spriteX(x_m), .spriteY(y_m), .sprite_size(sz_m), .dir(d_m),
        .anim_frame(a_m), .moving(mv_m), .frame_tick(ft_m)
    );

    link_motion_ctrl #(.X_START(3)) dut_l (
        .vga_clk(clk), .Reset(rst_l), .vs(vs), .keycode(keycode), .collision(collision),
        .spriteX(x_l), .spriteY(y_l), .sprite_size(sz_l), .dir(d_l),
        .anim_frame(a_l), .moving(mv_l), .frame_tick(ft_l)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // One video frame: key/collision valid on the tick cycle, noise elsewhere
    task automatic frame(input int tgt, input logic [7:0] key, input logic coll,
                         input int ex, input int ey, input int ed, input int em, input int ea);
        exp_t e;
        e.x = ex; e.y = ey; e.d = ed; e.m = em; e.a = ea;
        if (tgt == 0) q_m.push_back(e);
        else          q_l.push_back(e);
        @(posedge clk); #1;
        keycode   = key;
        collision = coll;
        vs        = 1'b1;
        @(posedge clk); #1;
        keycode   = 8'h16;
        collision = ~coll;
        repeat (2) @(posedge clk);
        #1 vs = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    // Monitor for the default-parameter instance
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ft_m) begin
                if (q_m.size() == 0) begin
                    chk("m_spurious_tick", 1, 0);
                end else begin
                    e = q_m.pop_front();
                    chk("m_spriteX", int'(x_m), e.x);
                    chk("m_spriteY", int'(y_m), e.y);
                    chk("m_dir", int'(d_m), e.d);
                    chk("m_moving", int'(mv_m), e.m);
                    chk("m_anim", int'(a_m), e.a);
                end
            end
        end
    end

    // Monitor for the X_START=3 instance
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ft_l) begin
                if (q_l.size() == 0) begin
                    chk("l_spurious_tick", 1, 0);
                end else begin
                    e = q_l.pop_front();
                    chk("l_spriteX", int'(x_l), e.x);
                    chk("l_spriteY", int'(y_l), e.y);
                    chk("l_dir", int'(d_l), e.d);
                    chk("l_moving", int'(mv_l), e.m);
                    chk("l_anim", int'(a_l), e.a);
                end
            end
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vs = 1'b0; keycode = 8'h00; collision = 1'b0;
        rst_m = 1'b1; rst_l = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_spriteX", int'(x_m), 304);
        chk("rst_spriteY", int'(y_m), 224);
        chk("rst_dir", int'(d_m), 0);
        chk("rst_anim", int'(a_m), 0);
        chk("rst_moving", int'(mv_m), 0);
        chk("rst_frame_tick", int'(ft_m), 0);
        chk("sprite_size", int'(sz_m), 32);

        // Left clamp on the X_START=3 instance: 1, 0, then holds at 0
        rst_l = 1'b0;
        frame(1, 8'h04, 1'b0, 1, 224, 2, 1, 0);
        frame(1, 8'h04, 1'b0, 0, 224, 2, 1, 0);
        frame(1, 8'h04, 1'b0, 0, 224, 2, 1, 0);
        frame(1, 8'h04, 1'b0, 0, 224, 2, 1, 0);
        rst_l = 1'b1;

        rst_m = 1'b0;
        // Idle frames with no key
        for (int i = 0; i < 3; i++) frame(0, 8'h00, 1'b0, 304, 224, 0, 0, 0);
        // Right walk, animation toggles after the 8th frame
        for (int i = 1; i <= 10; i++)
            frame(0, 8'h07, 1'b0, 304 + 2 * i, 224, 3, 1, (i >= 8) ? 1 : 0);
        frame(0, 8'h00, 1'b0, 324, 224, 3, 0, 1);
        // Up walk then collision restores previous position
        for (int i = 1; i <= 3; i++)
            frame(0, 8'h1A, 1'b0, 324, 224 - 2 * i, 1, 1, 1);
        frame(0, 8'h1A, 1'b1, 324, 220, 1, 0, 1);
        for (int i = 1; i <= 8; i++)
            frame(0, 8'h1A, 1'b0, 324, 220, 1, 0, 1);
        frame(0, 8'h1A, 1'b0, 324, 218, 1, 1, 1);
        // Collide again, then escape downwards while blocked
        frame(0, 8'h1A, 1'b1, 324, 220, 1, 0, 1);
        repeat (2) frame(0, 8'h1A, 1'b0, 324, 220, 1, 0, 1);
        frame(0, 8'h16, 1'b0, 324, 222, 0, 1, 1);
        frame(0, 8'h00, 1'b0, 324, 222, 0, 0, 1);
        frame(0, 8'h1A, 1'b0, 324, 220, 1, 1, 1);

        // Reset on the tick cycle: tick discarded, reset values win
        @(posedge clk); #1;
        keycode = 8'h07; vs = 1'b1; rst_m = 1'b1;
        @(posedge clk); #1;
        chk("race_spriteX", int'(x_m), 304);
        chk("race_spriteY", int'(y_m), 224);
        chk("race_dir", int'(d_m), 0);
        chk("race_moving", int'(mv_m), 0);
        chk("race_anim", int'(a_m), 0);
        chk("race_frame_tick", int'(ft_m), 0);
        rst_m = 1'b0; vs = 1'b0; keycode = 8'h00;
        repeat (3) @(posedge clk);

        // Right walk to X_MAX, then clamp and hold
        for (int i = 1; i <= 154; i++)
            frame(0, 8'h07, 1'b0, (304 + 2 * i > 608) ? 608 : 304 + 2 * i, 224, 3, 1, (i / 8) % 2);

        repeat (4) @(posedge clk);
        chk("queue_m_drained", q_m.size(), 0);
        chk("queue_l_drained", q_l.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
